// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep result path.
package sweep_pkg;

  localparam int N_POINTS   = 200;
  localparam int FREQ_WIDTH = 32;
  localparam int RES_WIDTH  = 32;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_CAPTURE,
    SB_DRAIN
  } sb_state_t;

  // Field order places freq in the MSBs of the packed record.
  typedef struct packed {
    logic        [FREQ_WIDTH-1:0] freq;
    logic signed [RES_WIDTH-1:0]  modulo;
    logic signed [RES_WIDTH-1:0]  phase;
  } sweep_rec_t;

  localparam int REC_WIDTH = $bits(sweep_rec_t);

  // Builds a record from its fields; bits are copied as-is.
  function automatic sweep_rec_t make_rec(
    input logic        [FREQ_WIDTH-1:0] freq,
    input logic signed [RES_WIDTH-1:0]  modulo,
    input logic signed [RES_WIDTH-1:0]  phase
  );
    sweep_rec_t rec;
    rec.freq   = freq;
    rec.modulo = modulo;
    rec.phase  = phase;
    return rec;
  endfunction

endpackage

// File: rtl/sweep_result_buffer_if.sv
// Valid/ready record stream towards the host link.
interface sweep_result_buffer_if;
  import sweep_pkg::*;

  logic       m_valid;
  logic       m_ready;
  sweep_rec_t m_data;
  logic       m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/result_ram.sv
// Simple dual-port record store: one write port, one registered read port.
module result_ram #(
  parameter int DEPTH      = 200,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 96
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port: no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: output register holds its value while i_rd_en is low.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sweep_result_buffer.sv
// Captures one {freq, MODULO, PHASE} record per fin2 strobe during a sweep,
// then streams the records in capture order once fin arrives.
module sweep_result_buffer
  import sweep_pkg::*;
#(
  parameter int DEPTH      = N_POINTS,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                        clk125,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        fin2,
  input  logic                        fin,
  input  logic        [FREQ_WIDTH-1:0] incrementado,
  input  logic signed [RES_WIDTH-1:0]  MODULO,
  input  logic signed [RES_WIDTH-1:0]  PHASE,
  sweep_result_buffer_if.master        m_if,
  output logic                        busy,
  output logic        [ADDR_WIDTH:0]   count,
  output logic                        overflow,
  output logic                        done
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  sb_state_t             r_state;
  sb_state_t             w_state_next;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_overflow;
  logic                  r_done;
  logic                  r_ram_vld;   // RAM output register holds an unconsumed record
  logic                  r_ram_last;  // that record is the final one of the sweep
  logic                  r_out_valid;
  logic                  r_out_last;
  sweep_rec_t            r_out_data;
  sweep_rec_t            w_ram_q;
  sweep_rec_t            w_wr_rec;
  logic                  w_wr_en;
  logic                  w_drop;
  logic [ADDR_WIDTH:0]   w_count_after;
  logic                  w_hs;
  logic                  w_out_load;
  logic                  w_rd_en;
  logic                  w_capture_entry;
  logic                  w_drain_entry;

  assign w_wr_rec      = make_rec(incrementado, MODULO, PHASE);
  assign w_wr_en       = (r_state == SB_CAPTURE) && fin2 && (r_count < DEPTH_C);
  assign w_drop        = (r_state == SB_CAPTURE) && fin2 && (r_count == DEPTH_C);
  // A write coinciding with fin still belongs to this sweep.
  assign w_count_after = r_count + {{ADDR_WIDTH{1'b0}}, w_wr_en};

  assign w_hs       = r_out_valid && m_if.m_ready;
  assign w_out_load = r_ram_vld && (!r_out_valid || w_hs);
  // Fetch the next record when the RAM output slot is empty or being emptied.
  assign w_rd_en    = (r_state == SB_DRAIN) && (r_rd_ptr < r_count) &&
                      (!r_ram_vld || w_out_load);

  assign w_capture_entry = (r_state == SB_IDLE) && (w_state_next == SB_CAPTURE);
  assign w_drain_entry   = (r_state == SB_CAPTURE) && (w_state_next == SB_DRAIN);

  result_ram #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (REC_WIDTH)
  ) u_result_ram (
    .clk       (clk125),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_rec),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rd_data (w_ram_q)
  );

  // State register.
  always_ff @(posedge clk125) begin
    if (reset) begin
      r_state <= SB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; strobes outside their owning state are ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SB_IDLE: begin
        if (start) w_state_next = SB_CAPTURE;
      end
      SB_CAPTURE: begin
        if (fin) w_state_next = (w_count_after == '0) ? SB_IDLE : SB_DRAIN;
      end
      SB_DRAIN: begin
        if (w_hs && r_out_last) w_state_next = SB_IDLE;
      end
      default: w_state_next = SB_IDLE;
    endcase
  end

  // Capture bookkeeping: write pointer, record count, sticky overflow, done pulse.
  always_ff @(posedge clk125) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state != SB_IDLE) && (w_state_next == SB_IDLE);
      if (w_capture_entry) begin
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_count  <= r_count + 1'b1;
        end
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // Read side: pointer and tracking of the record sitting in the RAM output register.
  always_ff @(posedge clk125) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_ram_vld  <= 1'b0;
      r_ram_last <= 1'b0;
    end else if (w_drain_entry) begin
      r_rd_ptr   <= '0;
      r_ram_vld  <= 1'b0;
      r_ram_last <= 1'b0;
    end else if (w_rd_en) begin
      r_rd_ptr   <= r_rd_ptr + 1'b1;
      r_ram_vld  <= 1'b1;
      r_ram_last <= (r_rd_ptr == r_count - 1'b1);
    end else if (w_out_load) begin
      r_ram_vld  <= 1'b0;
    end
  end

  // Output register: loads from the RAM stage, holds until accepted.
  always_ff @(posedge clk125) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_out_load) begin
      r_out_valid <= 1'b1;
      r_out_last  <= r_ram_last;
      r_out_data  <= w_ram_q;
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign m_if.m_valid = r_out_valid;
  assign m_if.m_last  = r_out_last;
  assign m_if.m_data  = r_out_data;
  assign busy         = (r_state != SB_IDLE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign done         = r_done;

endmodule
